// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared types and constants for the DSP48A1 multiply-accumulate sequencer.
// OPMODE values are the X/Z multiplexer selects presented to the external slice.
package dsp_mac_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] OPM_MUL  = 8'h01;  // X=M, Z=0
  localparam logic [7:0] OPM_MAC  = 8'h09;  // X=M, Z=P
  localparam logic [7:0] OPM_HOLD = 8'h08;  // X=0, Z=P
  localparam logic [7:0] OPM_NOP  = 8'h00;

  localparam int DRAIN_W = 4;

endpackage

// File: rtl/dsp_mac_sequencer.sv
// Streams operand beats into an external DSP48A1, flushes its pipeline after the
// last beat of a job and holds the accumulated result until it is accepted.
//
//   state | meaning
//   IDLE  | waiting for the first beat of a job; DSP disabled
//   ISSUE | accepting further beats; bubbles freeze the DSP pipeline
//   DRAIN | feeding P-hold cycles until the last product reaches dsp_p
//   HOLD  | result presented on m_p/m_count until m_ready
module dsp_mac_sequencer
  import dsp_mac_sequencer_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [17:0]      s_a,
  input  logic [17:0]      s_b,
  input  logic             s_last,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  input  logic [47:0]      dsp_p,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [47:0]      m_p,
  output logic [CNT_W-1:0] m_count
);

  localparam logic [DRAIN_W-1:0] LAT_LD = DRAIN_W'(LATENCY);

  state_t             state_q, state_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;

  logic [17:0]        dsp_a_d, dsp_b_d;
  logic [7:0]         dsp_opmode_d;
  logic               dsp_ce_d;
  logic               m_valid_d;
  logic [47:0]        m_p_d;
  logic [CNT_W-1:0]   m_count_d;

  logic               xfer;

  assign s_ready = (state_q == ST_IDLE) || (state_q == ST_ISSUE);
  assign xfer    = s_valid && s_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      dsp_a       <= '0;
      dsp_b       <= '0;
      dsp_opmode  <= OPM_NOP;
      dsp_ce      <= 1'b0;
      m_valid     <= 1'b0;
      m_p         <= '0;
      m_count     <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      dsp_a       <= dsp_a_d;
      dsp_b       <= dsp_b_d;
      dsp_opmode  <= dsp_opmode_d;
      dsp_ce      <= dsp_ce_d;
      m_valid     <= m_valid_d;
      m_p         <= m_p_d;
      m_count     <= m_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (xfer) state_d = s_last ? ST_DRAIN : ST_ISSUE;
      ST_ISSUE: if (xfer && s_last) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_cnt_q == '0) state_d = ST_HOLD;
      ST_HOLD:  if (m_valid && m_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values for the registered DSP controls and result outputs.
  always_comb begin
    dsp_a_d      = '0;
    dsp_b_d      = '0;
    dsp_opmode_d = OPM_NOP;
    dsp_ce_d     = 1'b0;
    drain_cnt_d  = drain_cnt_q;
    m_valid_d    = m_valid;
    m_p_d        = m_p;
    m_count_d    = m_count;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          dsp_a_d      = s_a;
          dsp_b_d      = s_b;
          dsp_opmode_d = OPM_MUL;
          dsp_ce_d     = 1'b1;
          m_count_d    = CNT_W'(1);
          if (s_last) drain_cnt_d = LAT_LD;
        end
      end
      ST_ISSUE: begin
        if (xfer) begin
          dsp_a_d      = s_a;
          dsp_b_d      = s_b;
          dsp_opmode_d = OPM_MAC;
          dsp_ce_d     = 1'b1;
          if (!(&m_count)) m_count_d = m_count + CNT_W'(1);
          if (s_last) drain_cnt_d = LAT_LD;
        end else begin
          // Bubble: keep the operands parked, only the enable drops.
          dsp_a_d      = dsp_a;
          dsp_b_d      = dsp_b;
          dsp_opmode_d = dsp_opmode;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q != '0) begin
          dsp_opmode_d = OPM_HOLD;
          dsp_ce_d     = 1'b1;
          drain_cnt_d  = drain_cnt_q - DRAIN_W'(1);
        end else begin
          m_p_d     = dsp_p;
          m_valid_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (m_ready) m_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench: behavioural DSP48A1 model, directed job table, random
// jobs checked against a sum-of-products reference, and a mid-drain reset.
module tb_dsp_mac_sequencer;

  localparam int LAT  = 4;
  localparam int CW   = 4;
  localparam int MAXB = 20;

  logic          CLK = 1'b0;
  logic          RST;
  logic          s_valid, s_ready, s_last;
  logic [17:0]   s_a, s_b;
  logic [17:0]   dsp_a, dsp_b;
  logic [7:0]    dsp_opmode;
  logic          dsp_ce;
  logic [47:0]   dsp_p;
  logic          m_valid, m_ready;
  logic [47:0]   m_p;
  logic [CW-1:0] m_count;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  dsp_mac_sequencer #(.LATENCY(LAT), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce),
    .dsp_p(dsp_p),
    .m_valid(m_valid), .m_ready(m_ready), .m_p(m_p), .m_count(m_count)
  );

  // Behavioural DSP slice: accumulator followed by a LAT-deep enabled delay line.
  logic signed [47:0] acc, ea, eb, nxt;
  logic [47:0]        pipe [LAT];
  assign dsp_p = pipe[LAT-1];

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc <= '0;
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else if (dsp_ce) begin
      ea = {{30{dsp_a[17]}}, dsp_a};
      eb = {{30{dsp_b[17]}}, dsp_b};
      case (dsp_opmode)
        8'h01:   nxt = ea * eb;
        8'h09:   nxt = acc + ea * eb;
        default: nxt = acc;
      endcase
      acc     <= nxt;
      pipe[0] <= nxt;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  typedef struct packed {
    logic        ce;
    logic [7:0]  op;
    logic [17:0] a;
    logic [17:0] b;
  } obs_t;

  obs_t log_q[$];
  bit   log_en = 1'b0;

  always @(negedge CLK) if (log_en) log_q.push_back({dsp_ce, dsp_opmode, dsp_a, dsp_b});

  typedef struct {
    int          n;
    int          a[MAXB];
    int          b[MAXB];
    int          gap[MAXB];
    int          hold;
    logic [47:0] exp_p;
    int          exp_cnt;
  } job_t;

  job_t tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic job_t mk(input int n, input int hold, input logic [47:0] p, input int cnt);
    job_t j;
    j.n = n; j.hold = hold; j.exp_p = p; j.exp_cnt = cnt;
    for (int i = 0; i < MAXB; i++) begin j.a[i] = 0; j.b[i] = 0; j.gap[i] = 0; end
    return j;
  endfunction

  // Reference: result is the plain sum of products, count saturates at all-ones.
  function automatic job_t with_ref(input job_t j);
    longint sum = 0;
    job_t   r = j;
    for (int i = 0; i < j.n; i++) sum += longint'(j.a[i]) * longint'(j.b[i]);
    r.exp_p   = sum[47:0];
    r.exp_cnt = (j.n > (2**CW - 1)) ? (2**CW - 1) : j.n;
    return r;
  endfunction

  task automatic drive_beats(input job_t j);
    bit rdy_ok = 1'b1;
    for (int i = 0; i < j.n; i++) begin
      for (int g = 0; g < j.gap[i]; g++) begin
        s_valid = 1'b0;
        s_last  = 1'($urandom_range(0, 1));
        m_ready = 1'($urandom_range(0, 1));
        @(negedge CLK);
      end
      s_valid = 1'b1;
      s_a     = 18'(j.a[i]);
      s_b     = 18'(j.b[i]);
      s_last  = (i == j.n - 1);
      m_ready = 1'($urandom_range(0, 1));
      if (s_ready !== 1'b1) rdy_ok = 1'b0;
      @(negedge CLK);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    chk("s_ready_during_beats", rdy_ok, 1'b1);
  endtask

  task automatic run_job(input job_t j);
    int    k = 0;
    bit    ok = 1'b1;
    obs_t  exp_ops[$];
    obs_t  act_ops[$];
    int    first = -1, last = -1, bubbles = 0, exp_bubbles = 0;
    bit    seq_ok;
    log_q.delete();
    log_en = 1'b1;
    drive_beats(j);
    while (m_valid !== 1'b1 && k < 60) begin
      @(negedge CLK);
      k++;
    end
    chk("result_latency", k, LAT + 1);
    chk("m_p", m_p, j.exp_p);
    chk("m_count", m_count, j.exp_cnt);
    for (int h = 0; h < j.hold; h++) begin
      if (m_valid !== 1'b1 || m_p !== j.exp_p || m_count !== CW'(j.exp_cnt) ||
          s_ready !== 1'b0 || dsp_ce !== 1'b0) ok = 1'b0;
      @(negedge CLK);
    end
    chk("hold_stable", ok, 1'b1);
    m_ready = 1'b1;
    @(negedge CLK);
    m_ready = 1'b0;
    chk("release_to_idle", {m_valid, s_ready}, 2'b01);
    log_en = 1'b0;

    for (int i = 0; i < j.n; i++) begin
      exp_ops.push_back({1'b1, (i == 0) ? 8'h01 : 8'h09, 18'(j.a[i]), 18'(j.b[i])});
      if (i > 0) exp_bubbles += j.gap[i];
    end
    for (int i = 0; i < LAT; i++) exp_ops.push_back({1'b1, 8'h08, 18'd0, 18'd0});
    foreach (log_q[i]) if (log_q[i].ce) begin
      if (first < 0) first = i;
      last = i;
      act_ops.push_back(log_q[i]);
    end
    for (int i = first; i >= 0 && i <= last; i++) if (!log_q[i].ce) bubbles++;
    seq_ok = (act_ops.size() == exp_ops.size());
    if (seq_ok) foreach (exp_ops[i]) if (act_ops[i] !== exp_ops[i]) seq_ok = 1'b0;
    chk("dsp_op_sequence", {act_ops.size(), 31'd0, seq_ok}, {exp_ops.size(), 31'd0, 1'b1});
    chk("dsp_ce_bubbles", bubbles, exp_bubbles);
  endtask

  initial begin
    job_t j;
    bit   quiet;

    tbl[0] = mk(1, 0, 48'd15, 1);
    tbl[0].a[0] = 3; tbl[0].b[0] = 5;
    tbl[1] = mk(4, 1, 48'd100, 4);
    for (int i = 0; i < 4; i++) begin tbl[1].a[i] = 2*i + 1; tbl[1].b[i] = 2*i + 2; end
    tbl[2] = tbl[1];
    tbl[2].gap[2] = 3;
    tbl[3] = mk(2, 5, 48'hFFFF_FFFF_FFE6, 2);
    tbl[3].a[0] = -2; tbl[3].b[0] = 3; tbl[3].a[1] = 4; tbl[3].b[1] = -5;
    tbl[4] = mk(20, 2, 48'd20, 15);
    for (int i = 0; i < 20; i++) begin tbl[4].a[i] = 1; tbl[4].b[i] = 1; tbl[4].gap[i] = i % 3; end

    RST = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0;
    #1;
    chk("reset_outputs", {dsp_ce, dsp_opmode, dsp_a, dsp_b, m_valid}, '0);
    chk("reset_result", {m_p, m_count}, '0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_after_reset", {s_ready, m_valid, dsp_ce}, 3'b100);

    foreach (tbl[t]) run_job(tbl[t]);

    for (int r = 0; r < 20; r++) begin
      j = mk(int'($urandom_range(1, 8)), int'($urandom_range(0, 3)), '0, 0);
      for (int i = 0; i < j.n; i++) begin
        j.a[i]   = int'($urandom_range(0, 262143)) - 131072;
        j.b[i]   = int'($urandom_range(0, 262143)) - 131072;
        j.gap[i] = int'($urandom_range(0, 2));
      end
      run_job(with_ref(j));
    end

    // Reset in the middle of the drain phase discards the job.
    j = mk(2, 0, '0, 0);
    j.a[0] = 3; j.b[0] = 5; j.a[1] = 1; j.b[1] = 1;
    drive_beats(j);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("rst_drain_dsp", {dsp_ce, dsp_opmode, dsp_a, dsp_b}, '0);
    chk("rst_drain_result", {m_valid, m_p, m_count}, '0);
    chk("rst_drain_ready", s_ready, 1'b1);
    @(negedge CLK);
    RST = 1'b0;
    quiet = 1'b1;
    repeat (12) begin
      if (m_valid !== 1'b0) quiet = 1'b0;
      @(negedge CLK);
    end
    chk("no_m_valid_after_rst", quiet, 1'b1);
    j = mk(1, 1, 48'd4, 1);
    j.a[0] = 2; j.b[0] = 2;
    run_job(j);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsp_mac_sequencer.md
DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, meaning DSP48A1 cycles from an enabled operand beat on dsp_a/dsp_b/dsp_opmode to its result on dsp_p (legal 1..15).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the beat counter.
REQ-003 CLK  input  1  clock; all logic on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 s_valid  input  1  operand beat valid.
REQ-006 s_ready  output  1  block accepts a beat this cycle.
REQ-007 s_a, s_b  input  18 each  signed operand pair.
REQ-008 s_last  input  1  final beat of the current job.
REQ-009 dsp_a, dsp_b  output  18 each  registered operands to the DSP slice.
REQ-010 dsp_opmode  output  8  registered OPMODE, aligned with dsp_a/dsp_b.
REQ-011 dsp_ce  output  1  registered clock enable for every DSP pipeline register.
REQ-012 dsp_p  input  48  DSP P output.
REQ-013 m_valid  output  1  job result valid; m_ready  input  1  result accepted.
REQ-014 m_p  output  48  accumulated result; m_count  output  CNT_W  beats in the job.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, DRAIN, HOLD.
REQ-016 s_ready SHALL be 1 in IDLE and ISSUE, 0 in DRAIN and HOLD; a beat transfers when s_valid and s_ready are both 1.
REQ-017 On a transfer, the next edge SHALL load dsp_a=s_a, dsp_b=s_b, dsp_ce=1, dsp_opmode=8'h01 (X=M, Z=0) for the first beat of a job, else 8'h09 (X=M, Z=P).
REQ-018 IDLE, first transfer: go ISSUE, or go DRAIN if s_last=1; m_count := 1.
REQ-019 ISSUE, transfer: m_count increments, saturating at all-ones; s_last=1 -> DRAIN.
REQ-020 ISSUE without transfer (bubble): dsp_ce SHALL be 0 next cycle, freezing the DSP pipeline; no state change.
REQ-021 DRAIN: dsp_ce=1, dsp_opmode=8'h08 (X=0, Z=P, P holds), dsp_a=dsp_b=0 for exactly LATENCY cycles, counted by a down-counter loaded on entry.
REQ-022 The cycle after the last-beat cycle with dsp_ce=1, plus LATENCY enabled cycles, the block SHALL capture dsp_p into m_p, assert m_valid and enter HOLD.
REQ-023 HOLD: m_p and m_count stable and m_valid=1 until m_valid and m_ready both 1, then IDLE with m_valid=0 on the next edge.
REQ-024 IDLE and HOLD: dsp_ce=0, dsp_opmode=8'h00, dsp_a=dsp_b=0.
REQ-025 m_ready while m_valid=0 SHALL be ignored; s_last with s_valid=0 SHALL be ignored.
REQ-026 A back-to-back job SHALL start no earlier than the cycle after HOLD exits (s_ready=1 in IDLE).

Reset
REQ-027 RST=1 SHALL asynchronously force state=IDLE, dsp_ce=0, dsp_opmode=8'h00, dsp_a=dsp_b=0, m_valid=0, m_p=0, m_count=0, drain counter=0.
REQ-028 RST mid-job SHALL discard the job with no m_valid; first beat after release uses opmode 8'h01.

Structure
REQ-029 A shared package SHALL hold the FSM state enum and OPMODE constants OPM_MUL=8'h01, OPM_MAC=8'h09, OPM_HOLD=8'h08, OPM_NOP=8'h00.
REQ-030 The DSP48A1 slice SHALL be external; the block contains only the FSM, counters and output registers, no sub-module.

Verification
REQ-031 Single beat s_a=3, s_b=5, s_last=1, behavioural DSP LATENCY=4 -> opmode 01 once, 4 HOLD-opmode cycles, m_p=15, m_count=1.
REQ-032 Four beats (1,2),(3,4),(5,6),(7,8) continuous -> opmodes 01,09,09,09, m_p=100, m_count=4.
REQ-033 Same job with s_valid low for 3 cycles after beat 2 -> dsp_ce=0 for those 3 cycles, m_p=100, m_count=4.
REQ-034 Signed (-2,3),(4,-5) -> m_p=48'hFFFF_FFFF_FFE6 (-26), m_count=2.
REQ-035 m_ready held 0 for 5 cycles in HOLD -> m_valid, m_p, m_count stable, s_ready=0; m_ready=1 -> IDLE next edge.
REQ-036 RST pulsed during DRAIN -> immediate outputs per REQ-027, no m_valid; next job (2,2) -> m_p=4.
